// File: rtl/dac_sample_fifo_pkg.sv
// Shared definitions for the DAC sample buffer: register offsets, status bit
// positions, reset values and the bus address decoder.
package dac_sample_fifo_pkg;

  localparam logic [15:0] OFF_SAMPLE = 16'd0;
  localparam logic [15:0] OFF_RATE   = 16'd1;
  localparam logic [15:0] OFF_STATUS = 16'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_UNF   = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_FLUSH = 7;

  localparam logic [7:0] DAC_MID = 8'h80;
  localparam logic [7:0] DIV_RST = 8'hFF;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SAMPLE,
    SEL_RATE,
    SEL_STATUS
  } reg_sel_e;

  // Offset arithmetic wraps in 16 bits, so a BASE near the top of memory still decodes.
  function automatic reg_sel_e decode(input logic [15:0] addr, input logic [15:0] base);
    logic [15:0] off;
    off = addr - base;
    if (off == OFF_SAMPLE)      decode = SEL_SAMPLE;
    else if (off == OFF_RATE)   decode = SEL_RATE;
    else if (off == OFF_STATUS) decode = SEL_STATUS;
    else                        decode = SEL_NONE;
  endfunction

endpackage

// File: rtl/dac_sample_fifo_sync_fifo.sv
// Small synchronous FIFO with push/pop/flush. A pop in the same cycle frees
// a slot, so a push into a full FIFO is accepted when a pop also happens.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic                     pop_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [$clog2(DEPTH):0] count_reg;

  assign count   = count_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);
  assign head    = mem[rd_ptr_reg];

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_fifo.sv
// CPU-mapped DAC sample buffer: the CPU pushes samples, and a programmable
// rate timer moves one sample per period into the DAC output register.
module dac_sample_fifo
  import dac_sample_fifo_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter int          PRE   = 16,
  parameter logic [15:0] BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we_n,
  output logic [7:0]  dac_out,
  output logic        rd_hit,
  output logic [7:0]  rd_data
);

  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

  logic          we_q_reg;
  logic [PW-1:0] pre_cnt_reg;
  logic [7:0]    div_cnt_reg;
  logic [7:0]    div_reg;
  logic [7:0]    dac_reg;
  logic          ovf_reg;
  logic          unf_reg;

  reg_sel_e wr_sel;
  reg_sel_e rd_sel;
  logic     wr_ev;
  logic     push_ev;
  logic     rate_we;
  logic     status_we;
  logic     flush;
  logic     pre_wrap;
  logic     div_wrap;
  logic     tick;
  logic     ovf_set;
  logic     unf_set;
  logic     ovf_clr;
  logic     unf_clr;
  logic [7:0] status;
  logic [3:0] count4;

  logic [7:0]              fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push_ok;
  logic                    fifo_pop_ok;

  // One write event per strobe: only the falling edge of we_n counts.
  assign wr_ev     = !we_n && we_q_reg;
  assign wr_sel    = decode(addr, BASE);
  assign push_ev   = wr_ev && (wr_sel == SEL_SAMPLE);
  assign rate_we   = wr_ev && (wr_sel == SEL_RATE);
  assign status_we = wr_ev && (wr_sel == SEL_STATUS);
  assign flush     = status_we && wdata[ST_FLUSH];
  assign ovf_clr   = status_we && wdata[ST_OVF];
  assign unf_clr   = status_we && wdata[ST_UNF];

  assign pre_wrap = (pre_cnt_reg == PRE_LAST);
  assign div_wrap = (div_cnt_reg == div_reg);
  assign tick     = pre_wrap && div_wrap;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_ev),
    .pop     (tick),
    .flush   (flush),
    .wdata   (wdata),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (fifo_push_ok),
    .pop_ok  (fifo_pop_ok)
  );

  // A push can never coincide with a flush, so a refused push always means full.
  assign ovf_set = push_ev && !fifo_push_ok;
  assign unf_set = tick && fifo_empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q_reg <= 1'b1;
    end else begin
      we_q_reg <= we_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
      div_cnt_reg <= '0;
    end else if (rate_we) begin
      pre_cnt_reg <= '0;
      div_cnt_reg <= '0;
    end else if (pre_wrap) begin
      pre_cnt_reg <= '0;
      div_cnt_reg <= div_wrap ? 8'd0 : div_cnt_reg + 8'd1;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DIV_RST;
    end else if (rate_we) begin
      div_reg <= wdata;
    end
  end

  // A new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_set || (ovf_reg && !ovf_clr);
      unf_reg <= unf_set || (unf_reg && !unf_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_reg <= DAC_MID;
    end else if (fifo_pop_ok) begin
      dac_reg <= fifo_head;
    end
  end

  assign dac_out = dac_reg;
  assign count4  = 4'(fifo_count);

  always_comb begin
    status           = '0;
    status[7:4]      = count4;
    status[ST_OVF]   = ovf_reg;
    status[ST_UNF]   = unf_reg;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
  end

  assign rd_sel = decode(addr, BASE);
  assign rd_hit = (rd_sel == SEL_RATE) || (rd_sel == SEL_STATUS);

  always_comb begin
    rd_data = 8'h00;
    case (rd_sel)
      SEL_RATE:   rd_data = div_reg;
      SEL_STATUS: rd_data = status;
      default:    rd_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Scoreboard bench for dac_sample_fifo: a queue-based reference model predicts
// read data and DAC output changes; a separate monitor compares them.
module tb_dac_sample_fifo;

  localparam int          DEPTH = 8;
  localparam int          PRE   = 16;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] IDLE  = 16'h1234;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr  = IDLE;
  logic [7:0]  wdata = 8'h00;
  logic        we_n  = 1'b1;
  logic [7:0]  dac_out;
  logic        rd_hit;
  logic [7:0]  rd_data;

  dac_sample_fifo #(
    .DEPTH (DEPTH),
    .PRE   (PRE),
    .BASE  (BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .we_n    (we_n),
    .dac_out (dac_out),
    .rd_hit  (rd_hit),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rd_q[$];
  logic [7:0] dac_q[$];

  // Reference model: sample queue, sticky flags, and a clock count since the timer last restarted.
  logic [7:0] m_fifo[$];
  logic       m_ovf   = 1'b0;
  logic       m_unf   = 1'b0;
  logic       m_we_q  = 1'b1;
  logic [7:0] m_div   = 8'hFF;
  logic [7:0] m_dac   = 8'h80;
  int         m_since = 0;

  always @(negedge clk) begin
    logic [7:0] st;
    logic [7:0] new_dac;
    int         period;
    bit         wr_ev;
    bit         tick;
    bit         flush;
    bit         was_empty;
    bit         unf_set;
    if (!rst_n) begin
      m_fifo.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_we_q  = 1'b1;
      m_div   = 8'hFF;
      m_since = 0;
      if (m_dac != 8'h80) dac_q.push_back(8'h80);
      m_dac = 8'h80;
    end
    st = {4'(m_fifo.size()), m_ovf, m_unf, (m_fifo.size() == DEPTH), (m_fifo.size() == 0)};
    if (addr == BASE + 16'd1)      rd_q.push_back(m_div);
    else if (addr == BASE + 16'd2) rd_q.push_back(st);
    if (rst_n) begin
      period    = (int'(m_div) + 1) * PRE;
      wr_ev     = !we_n && m_we_q;
      tick      = (m_since == period - 1);
      flush     = wr_ev && (addr == BASE + 16'd2) && wdata[7];
      was_empty = (m_fifo.size() == 0);
      unf_set   = 1'b0;
      new_dac   = m_dac;
      if (tick && !flush) begin
        if (!was_empty) new_dac = m_fifo.pop_front();
        else            unf_set = 1'b1;
      end
      if (wr_ev && addr == BASE) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(wdata);
        else                       m_ovf = 1'b1;
      end
      if (wr_ev && addr == BASE + 16'd2) begin
        if (wdata[3]) m_ovf = 1'b0;
        if (wdata[2]) m_unf = 1'b0;
        if (wdata[7]) m_fifo.delete();
      end
      if (unf_set) m_unf = 1'b1;
      if (wr_ev && addr == BASE + 16'd1) begin
        m_div   = wdata;
        m_since = 0;
      end else begin
        m_since = (m_since + 1) % period;
      end
      m_we_q = we_n;
      if (new_dac != m_dac) begin
        dac_q.push_back(new_dac);
        m_dac = new_dac;
      end
    end
  end

  // Monitor: every register read and every DAC change is matched against the model's queues.
  initial begin
    logic [7:0] last_dac;
    logic [7:0] exp;
    last_dac = 8'h80;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      #1;
      if (rd_hit) begin
        n_checks++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: addr=%04h rd_data=%02h, no read was expected", addr, rd_data);
        end else begin
          exp = rd_q.pop_front();
          if (rd_data !== exp) begin
            n_fail++;
            $display("FAIL rd_data: addr=%04h got %02h expected %02h", addr, rd_data, exp);
          end else begin
            $display("read  addr=%04h data=%02h", addr, rd_data);
          end
        end
      end
      if (dac_out !== last_dac) begin
        n_checks++;
        if (dac_q.size() == 0) begin
          n_fail++;
          $display("FAIL dac_unexpected: dac_out changed %02h -> %02h, no change expected", last_dac, dac_out);
        end else begin
          exp = dac_q.pop_front();
          if (dac_out !== exp) begin
            n_fail++;
            $display("FAIL dac_out: got %02h expected %02h", dac_out, exp);
          end else begin
            $display("dac   %02h -> %02h", last_dac, dac_out);
          end
        end
        last_dac = dac_out;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
    addr  = a;
    wdata = d;
    we_n  = 1'b0;
    repeat (hold) step();
    we_n = 1'b1;
    addr = IDLE;
    step();
  endtask

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("check %s = %02h", name, act);
    end
  endtask

  task automatic read_expect(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    @(negedge clk);
    #2;
    check_eq(name, rd_data, exp);
    step();
    addr = IDLE;
  endtask

  initial begin
    logic [7:0] d;
    int         op;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    read_expect("status_after_reset", BASE + 16'd2, 8'h01);
    read_expect("rate_after_reset", BASE + 16'd1, 8'hFF);
    check_eq("dac_after_reset", dac_out, 8'h80);

    // div=0: three samples leave one tick (16 clocks) apart
    wr(BASE + 16'd1, 8'h00, 1);
    wr(BASE, 8'h10, 1);
    wr(BASE, 8'h20, 1);
    wr(BASE, 8'h30, 1);
    repeat (44) step();
    read_expect("status_after_3_ticks", BASE + 16'd2, 8'h01);
    check_eq("dac_after_3_ticks", dac_out, 8'h30);

    // Stall the timer, clear state, then one long strobe
    wr(BASE + 16'd1, 8'hFF, 1);
    wr(BASE + 16'd2, 8'h84, 1);
    wr(BASE, 8'h55, 5);
    read_expect("status_long_strobe", BASE + 16'd2, 8'h10);

    for (int i = 0; i < 8; i++) wr(BASE, 8'h61 + 8'(i), 1);
    read_expect("status_overflow", BASE + 16'd2, 8'h8A);
    wr(BASE + 16'd2, 8'h08, 1);
    read_expect("status_ovf_cleared", BASE + 16'd2, 8'h82);

    // Drain then underrun
    wr(BASE + 16'd1, 8'h00, 1);
    repeat (150) step();
    read_expect("status_underrun", BASE + 16'd2, 8'h05);
    check_eq("dac_holds_last", dac_out, 8'h67);

    // Push lands exactly on the 16th cycle after the rate write, i.e. on the tick
    wr(BASE + 16'd1, 8'h00, 1);
    wr(BASE + 16'd2, 8'h04, 1);
    repeat (12) step();
    wr(BASE, 8'hAB, 1);
    read_expect("status_push_on_tick", BASE + 16'd2, 8'h14);
    repeat (20) step();
    check_eq("dac_after_tick_push", dac_out, 8'hAB);

    // Flush with four entries held
    wr(BASE + 16'd1, 8'hFF, 1);
    wr(BASE + 16'd2, 8'h04, 1);
    for (int i = 0; i < 4; i++) wr(BASE, 8'h11 + 8'(i), 1);
    read_expect("status_four_held", BASE + 16'd2, 8'h40);
    wr(BASE + 16'd2, 8'h80, 1);
    read_expect("status_after_flush", BASE + 16'd2, 8'h01);
    check_eq("dac_after_flush", dac_out, 8'hAB);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      d  = 8'($urandom);
      case (op)
        0, 1, 2, 3: wr(BASE, d, int'($urandom_range(1, 3)));
        4, 5:       wr(BASE + 16'd1, 8'($urandom_range(0, 2)), int'($urandom_range(1, 2)));
        6: begin
          if ($urandom_range(0, 7) != 0) d[7] = 1'b0;
          wr(BASE + 16'd2, d, 1);
        end
        7: begin
          addr = ($urandom_range(0, 1) == 0) ? BASE + 16'd1 : BASE + 16'd2;
          step();
          addr = IDLE;
        end
        8:       repeat ($urandom_range(1, 20)) step();
        default: wr(BASE + 16'd3, d, 1);
      endcase
    end

    // Reset in the middle of a sample period
    wr(BASE + 16'd2, 8'h8C, 1);
    wr(BASE + 16'd1, 8'h01, 1);
    wr(BASE, 8'h21, 1);
    wr(BASE, 8'h22, 1);
    wr(BASE, 8'h23, 1);
    repeat (40) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("dac_async_reset", dac_out, 8'h80);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    read_expect("status_after_reset2", BASE + 16'd2, 8'h01);
    read_expect("rate_after_reset2", BASE + 16'd1, 8'hFF);

    repeat (5) step();
    n_checks++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_pending: %0d expected reads never seen, required 0", rd_q.size());
    end
    n_checks++;
    if (dac_q.size() != 0) begin
      n_fail++;
      $display("FAIL dac_pending: %0d expected dac changes never seen, required 0", dac_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
